// File: rtl/axi_wrapper_datapath_v2_if.sv
// Word-addressed register bus between an AXI front end and the wrapper datapath.
// A write is taken on every edge with axi_wr_en=1 (no backpressure); a read with
// axi_rd_en=1 returns axi_rd_msg with axi_rd_valid=1 exactly one cycle later.
interface axi_wrapper_datapath_v2_if;
    logic        axi_wr_en;
    logic [31:0] axi_wr_addr;
    logic [31:0] axi_wr_msg;
    logic        axi_rd_en;
    logic [31:0] axi_rd_addr;
    logic [31:0] axi_rd_msg;
    logic        axi_rd_valid;

    modport master (
        output axi_wr_en, axi_wr_addr, axi_wr_msg, axi_rd_en, axi_rd_addr,
        input  axi_rd_msg, axi_rd_valid
    );
    modport slave (
        input  axi_wr_en, axi_wr_addr, axi_wr_msg, axi_rd_en, axi_rd_addr,
        output axi_rd_msg, axi_rd_valid
    );
endinterface

// File: rtl/axi_wrapper_datapath_v2.sv
// Register file, DUT stimulus/response sequencer and per-chain scan capture buffers
// behind a word-addressed bus with one-cycle read latency.
module axi_wrapper_datapath_v2 #(
    parameter int P_SC_NBR    = 16,
    parameter int P_DUT_IN_W  = 256,
    parameter int P_DUT_OUT_W = 256,
    parameter int P_DFT_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    axi_wrapper_datapath_v2_if.slave  s_axi,
    output logic [P_DUT_IN_W-1:0]     o_dut_input_vec,
    input  logic [P_DUT_OUT_W-1:0]    i_dut_output_vec,
    input  logic [32*P_SC_NBR-1:0]    i_dft_output_data,
    input  logic [P_SC_NBR-1:0]       i_dft_output_valid,
    input  logic                      i_dft_clear,
    output logic [P_SC_NBR-1:0]       o_dft_full,
    input  logic [31:0]               i_ctrl_state,
    input  logic                      i_ctrl_state_wen,
    output logic [31:0]               o_ctrl_opcode,
    output logic [31:0]               o_ctrl_config,
    input  logic                      i_in_load_start,
    input  logic                      i_out_cap_start,
    output logic                      o_io_busy,
    output logic                      o_in_load_done,
    output logic                      o_out_cap_done,
    output logic [1:0]                o_dbg_state
);
    localparam int IN_WORDS  = (P_DUT_IN_W + 31) / 32;
    localparam int OUT_WORDS = (P_DUT_OUT_W + 31) / 32;
    localparam int MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam int IN_IW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_IW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int DFT_WORDS = P_SC_NBR * P_DFT_DEPTH;
    localparam int DFT_IW    = (DFT_WORDS > 1) ? $clog2(DFT_WORDS) : 1;
    localparam int PTR_W     = $clog2(P_DFT_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD_IN = 2'd1, ST_CAP_OUT = 2'd2} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [31:0]            r_opcode, r_config, r_ctrl_state, r_test;
    logic [31:0]            r_dut_in  [IN_WORDS];
    logic [31:0]            r_dut_out [OUT_WORDS];
    logic [31:0]            r_dft     [DFT_WORDS];
    logic [PTR_W-1:0]       r_ptr     [P_SC_NBR];
    logic [IN_WORDS*32-1:0] r_stage, w_stage_nxt;
    logic [OUT_WORDS*32-1:0] r_snap;
    logic [P_DUT_IN_W-1:0]  r_dut_in_vec;
    logic                   r_load_done, r_cap_done, r_rd_valid;
    logic [31:0]            r_rd_msg, w_rd_data;
    logic                   w_start_load, w_start_cap, w_load_step, w_cap_step, w_last, w_busy;
    logic [P_SC_NBR-1:0]    w_full;
    logic [IN_IW-1:0]       w_cnt_in;
    logic [OUT_IW-1:0]      w_cnt_out;
    logic [31:0]            w_wr_in_off, w_rd_in_off, w_rd_out_off, w_rd_dft_off;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Load start outranks capture start; starts outside IDLE are simply not looked at.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_load = 1'b0;
        w_start_cap  = 1'b0;
        w_load_step  = 1'b0;
        w_cap_step   = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_in_load_start) begin
                    w_start_load = 1'b1;
                    w_state_nxt  = ST_LOAD_IN;
                end else if (i_out_cap_start) begin
                    w_start_cap = 1'b1;
                    w_state_nxt = ST_CAP_OUT;
                end
            end
            ST_LOAD_IN: begin
                w_load_step = 1'b1;
                if (r_cnt == CNT_W'(IN_WORDS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CAP_OUT: begin
                w_cap_step = 1'b1;
                if (r_cnt == CNT_W'(OUT_WORDS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy    = (r_state != ST_IDLE);
    assign w_cnt_in  = r_cnt[IN_IW-1:0];
    assign w_cnt_out = r_cnt[OUT_IW-1:0];

    // Staging with the current word merged in, so the final copy and the vector update share an edge.
    always_comb begin
        w_stage_nxt = r_stage;
        w_stage_nxt[32*int'(w_cnt_in) +: 32] = r_dut_in[w_cnt_in];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_stage      <= '0;
            r_snap       <= '0;
            r_dut_in_vec <= '0;
            r_load_done  <= 1'b0;
            r_cap_done   <= 1'b0;
            for (int k = 0; k < OUT_WORDS; k++) r_dut_out[k] <= '0;
        end else begin
            if (w_start_load || w_start_cap) r_cnt <= '0;
            else if (w_load_step || w_cap_step) r_cnt <= r_cnt + 1'b1;
            if (w_start_cap) r_snap <= (OUT_WORDS*32)'(i_dut_output_vec);
            if (w_load_step) begin
                r_stage <= w_stage_nxt;
                if (w_last) r_dut_in_vec <= w_stage_nxt[P_DUT_IN_W-1:0];
            end
            if (w_cap_step) r_dut_out[w_cnt_out] <= r_snap[32*int'(w_cnt_out) +: 32];
            r_load_done <= w_load_step && w_last;
            r_cap_done  <= w_cap_step && w_last;
        end
    end

    assign w_wr_in_off = s_axi.axi_wr_addr - 32'h100;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode     <= '0;
            r_config     <= '0;
            r_test       <= '0;
            r_ctrl_state <= '0;
            for (int k = 0; k < IN_WORDS; k++) r_dut_in[k] <= '0;
        end else begin
            if (i_ctrl_state_wen) r_ctrl_state <= i_ctrl_state;
            if (s_axi.axi_wr_en) begin
                if (s_axi.axi_wr_addr == 32'h0)               r_opcode <= s_axi.axi_wr_msg;
                else if (s_axi.axi_wr_addr == 32'h2)          r_config <= s_axi.axi_wr_msg;
                else if (s_axi.axi_wr_addr == 32'hFF00_0000)  r_test   <= s_axi.axi_wr_msg;
                else if (w_wr_in_off < 32'(IN_WORDS))
                    r_dut_in[w_wr_in_off[IN_IW-1:0]] <= s_axi.axi_wr_msg;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < P_SC_NBR; i++) w_full[i] = (r_ptr[i] == PTR_W'(P_DFT_DEPTH));
    end

    // Clear rewinds pointers only; captured words stay readable until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < P_SC_NBR; i++) r_ptr[i] <= '0;
            for (int w = 0; w < DFT_WORDS; w++) r_dft[w] <= '0;
        end else if (i_dft_clear) begin
            for (int i = 0; i < P_SC_NBR; i++) r_ptr[i] <= '0;
        end else begin
            for (int i = 0; i < P_SC_NBR; i++) begin
                if (i_dft_output_valid[i] && !w_full[i]) begin
                    r_dft[DFT_IW'(i*P_DFT_DEPTH + int'(r_ptr[i]))] <= i_dft_output_data[32*i +: 32];
                    r_ptr[i] <= r_ptr[i] + 1'b1;
                end
            end
        end
    end

    assign w_rd_in_off  = s_axi.axi_rd_addr - 32'h100;
    assign w_rd_out_off = s_axi.axi_rd_addr - 32'h200;
    assign w_rd_dft_off = s_axi.axi_rd_addr - 32'h1000;

    always_comb begin
        w_rd_data = '0;
        if (s_axi.axi_rd_addr == 32'h0)              w_rd_data = r_opcode;
        else if (s_axi.axi_rd_addr == 32'h1)         w_rd_data = r_ctrl_state;
        else if (s_axi.axi_rd_addr == 32'h2)         w_rd_data = r_config;
        else if (s_axi.axi_rd_addr == 32'h3)         w_rd_data = {16'(w_full), 15'b0, w_busy};
        else if (s_axi.axi_rd_addr == 32'hFF00_0001) w_rd_data = r_test;
        else if (w_rd_in_off < 32'(IN_WORDS))        w_rd_data = r_dut_in[w_rd_in_off[IN_IW-1:0]];
        else if (w_rd_out_off < 32'(OUT_WORDS))      w_rd_data = r_dut_out[w_rd_out_off[OUT_IW-1:0]];
        else if (w_rd_dft_off < 32'(DFT_WORDS))      w_rd_data = r_dft[w_rd_dft_off[DFT_IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_msg   <= '0;
        end else begin
            r_rd_valid <= s_axi.axi_rd_en;
            r_rd_msg   <= s_axi.axi_rd_en ? w_rd_data : 32'h0;
        end
    end

    assign s_axi.axi_rd_msg   = r_rd_msg;
    assign s_axi.axi_rd_valid = r_rd_valid;
    assign o_dut_input_vec    = r_dut_in_vec;
    assign o_dft_full         = w_full;
    assign o_ctrl_opcode      = r_opcode;
    assign o_ctrl_config      = r_config;
    assign o_io_busy          = w_busy;
    assign o_in_load_done     = r_load_done;
    assign o_out_cap_done     = r_cap_done;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_axi_wrapper_datapath_v2.sv
// Directed bench: reads are scoreboarded through an expected queue popped by a
// negedge monitor; sequencer pulses are timed against the cycle counter.
module tb_axi_wrapper_datapath_v2;
    localparam int SC = 16;
    localparam int IW = 256;
    localparam int OW = 256;
    localparam int DD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [IW-1:0]   dut_input_vec;
    logic [OW-1:0]   dut_output_vec;
    logic [32*SC-1:0] dft_data;
    logic [SC-1:0]   dft_valid;
    logic            dft_clear;
    logic [SC-1:0]   dft_full;
    logic [31:0]     ctrl_state;
    logic            ctrl_state_wen;
    logic [31:0]     ctrl_opcode, ctrl_config;
    logic            in_load_start, out_cap_start;
    logic            io_busy, in_load_done, out_cap_done;
    logic [1:0]      dbg_state;

    axi_wrapper_datapath_v2_if axi ();

    axi_wrapper_datapath_v2 #(
        .P_SC_NBR(SC), .P_DUT_IN_W(IW), .P_DUT_OUT_W(OW), .P_DFT_DEPTH(DD)
    ) dut (
        .clk(clk), .reset(reset), .s_axi(axi),
        .o_dut_input_vec(dut_input_vec), .i_dut_output_vec(dut_output_vec),
        .i_dft_output_data(dft_data), .i_dft_output_valid(dft_valid),
        .i_dft_clear(dft_clear), .o_dft_full(dft_full),
        .i_ctrl_state(ctrl_state), .i_ctrl_state_wen(ctrl_state_wen),
        .o_ctrl_opcode(ctrl_opcode), .o_ctrl_config(ctrl_config),
        .i_in_load_start(in_load_start), .i_out_cap_start(out_cap_start),
        .o_io_busy(io_busy), .o_in_load_done(in_load_done),
        .o_out_cap_done(out_cap_done), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_load_done = 0, n_cap_done = 0;
    int          load_done_cyc = 0, cap_done_cyc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data);
        axi.axi_wr_en   = 1'b1;
        axi.axi_wr_addr = addr;
        axi.axi_wr_msg  = data;
        tick();
        axi.axi_wr_en   = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] addr, input logic [31:0] exp);
        axi.axi_rd_en   = 1'b1;
        axi.axi_rd_addr = addr;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1);
        tick();
        axi.axi_rd_en   = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (axi.axi_rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 256'(axi.axi_rd_msg), 256'hDEAD);
                end else begin
                    chk("rd_data", 256'(axi.axi_rd_msg), 256'(exp_q.pop_front()));
                    chk("rd_latency", 256'(cyc), 256'(exp_cyc_q.pop_front()));
                end
            end
            if (in_load_done) begin
                n_load_done++;
                load_done_cyc = cyc;
            end
            if (out_cap_done) begin
                n_cap_done++;
                cap_done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [IW-1:0] exp_vec;
    logic [OW-1:0] pat_vec;
    logic [31:0]   pat_word;
    int            start_cyc, before_ld, before_cap;

    initial begin
        reset = 1'b1;
        axi.axi_wr_en = 1'b0; axi.axi_wr_addr = '0; axi.axi_wr_msg = '0;
        axi.axi_rd_en = 1'b0; axi.axi_rd_addr = '0;
        dut_output_vec = '0; dft_data = '0; dft_valid = '0; dft_clear = 1'b0;
        ctrl_state = '0; ctrl_state_wen = 1'b0;
        in_load_start = 1'b0; out_cap_start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_vec", 256'(dut_input_vec), 256'h0);
        chk("rst_busy_full_done", 256'({io_busy, dft_full, in_load_done, out_cap_done, axi.axi_rd_valid}), 256'h0);
        chk("rst_ctrl", 256'({ctrl_opcode, ctrl_config}), 256'h0);
        axi_rd(32'h0, 32'h0);
        axi_rd(32'h3, 32'h0);

        // Loopback, WO read, RW regs, RO write ignored, state load, unmapped
        axi_wr(32'hFF00_0000, 32'hA5A5_0001);
        axi_rd(32'hFF00_0001, 32'hA5A5_0001);
        axi_rd(32'hFF00_0000, 32'h0);
        axi_wr(32'h0, 32'h0000_0011);
        axi_wr(32'h2, 32'hC0FF_EE00);
        axi_wr(32'h1, 32'h5555_5555);
        axi_rd(32'h2, 32'hC0FF_EE00);
        axi_rd(32'h1, 32'h0);
        chk("ctrl_outputs", 256'({ctrl_opcode, ctrl_config}), 256'({32'h11, 32'hC0FF_EE00}));
        ctrl_state = 32'h1234_5678; ctrl_state_wen = 1'b1;
        tick();
        ctrl_state_wen = 1'b0;
        axi_rd(32'h1, 32'h1234_5678);
        axi_wr(32'h50, 32'hFFFF_FFFF);
        axi_rd(32'h50, 32'h0);
        axi_rd(32'h208, 32'h0);

        // Same-cycle write and read of OPCODE returns the old value
        axi.axi_rd_en = 1'b1; axi.axi_rd_addr = 32'h0;
        exp_q.push_back(32'h11); exp_cyc_q.push_back(cyc + 1);
        axi_wr(32'h0, 32'h22);
        axi.axi_rd_en = 1'b0;
        axi_rd(32'h0, 32'h22);

        // Input load: word k = k+1
        exp_vec = '0;
        for (int k = 0; k < 8; k++) begin
            axi_wr(32'h100 + 32'(k), 32'(k + 1));
            exp_vec[32*k +: 32] = 32'(k + 1);
        end
        before_ld = n_load_done;
        in_load_start = 1'b1;
        start_cyc = cyc;
        tick();
        in_load_start = 1'b0;
        axi_rd(32'h3, 32'h1);
        for (int t = 0; t < 20; t++) begin
            if (n_load_done != before_ld) break;
            if (!in_load_done) chk("vec_before_done", 256'(dut_input_vec), 256'h0);
            tick();
        end
        chk("load_done_count", 256'(n_load_done - before_ld), 256'd1);
        chk("load_done_latency", 256'(load_done_cyc - start_cyc), 256'd9);
        chk("load_vec", 256'(dut_input_vec), 256'(exp_vec));
        axi_rd(32'h103, 32'h4);

        // Output capture: byte b of the vector = b; input changes right after start
        for (int k = 0; k < 8; k++) begin
            pat_word = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            pat_vec[32*k +: 32] = pat_word;
        end
        dut_output_vec = pat_vec;
        before_cap = n_cap_done;
        out_cap_start = 1'b1;
        start_cyc = cyc;
        tick();
        out_cap_start = 1'b0;
        dut_output_vec = ~pat_vec;
        for (int t = 0; t < 20 && n_cap_done == before_cap; t++) tick();
        chk("cap_done_count", 256'(n_cap_done - before_cap), 256'd1);
        chk("cap_done_latency", 256'(cap_done_cyc - start_cyc), 256'd9);
        axi_rd(32'h200, 32'h0302_0100);
        axi_rd(32'h201, 32'h0706_0504);
        axi_rd(32'h204, 32'h1312_1110);
        axi_rd(32'h207, 32'h1F1E_1D1C);

        // Simultaneous starts, then a capture start while busy
        before_ld = n_load_done; before_cap = n_cap_done;
        in_load_start = 1'b1; out_cap_start = 1'b1;
        tick();
        in_load_start = 1'b0;
        tick();
        out_cap_start = 1'b0;
        repeat (15) tick();
        chk("prio_load_count", 256'(n_load_done - before_ld), 256'd1);
        chk("prio_cap_count", 256'(n_cap_done - before_cap), 256'd0);

        // Scan chain 2: six words into a depth-4 buffer
        for (int k = 1; k <= 6; k++) begin
            dft_valid = 16'h0004;
            dft_data  = '0;
            dft_data[64 +: 32] = 32'(k);
            tick();
        end
        dft_valid = '0;
        chk("dft_full", 256'(dft_full), 256'h0004);
        axi_rd(32'h3, 32'h0004_0000);
        for (int j = 0; j < 4; j++) axi_rd(32'h1008 + 32'(j), 32'(j + 1));
        dft_clear = 1'b1; dft_valid = 16'h0004; dft_data[64 +: 32] = 32'h99;
        tick();
        dft_clear = 1'b0; dft_valid = '0;
        chk("dft_full_cleared", 256'(dft_full), 256'h0);
        dft_valid = 16'h0004; dft_data[64 +: 32] = 32'h77;
        tick();
        dft_valid = '0;
        axi_rd(32'h1008, 32'h77);
        axi_rd(32'h1009, 32'h2);

        // Reset three cycles into a load
        before_ld = n_load_done;
        in_load_start = 1'b1;
        tick();
        in_load_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 256'(io_busy), 256'h0);
        chk("midrst_vec", 256'(dut_input_vec), 256'h0);
        repeat (12) tick();
        chk("midrst_no_done", 256'(n_load_done - before_ld), 256'd0);
        axi_rd(32'h0, 32'h0);
        axi_rd(32'h1, 32'h0);
        axi_rd(32'h2, 32'h0);
        axi_rd(32'h3, 32'h0);
        axi_rd(32'h100, 32'h0);
        axi_rd(32'h207, 32'h0);
        axi_rd(32'h1009, 32'h0);
        axi_rd(32'hFF00_0001, 32'h0);

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) tick();
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wrapper_datapath_v2.md
AXI_WRAPPER_DATAPATH_V2 -- requirements
Module: axi_wrapper_datapath_v2

Interface
REQ-001 Parameter P_SC_NBR, default 16, number of scan chains (1..16).
REQ-002 Parameter P_DUT_IN_W, default 256, DUT input vector width (32..8192); IN_WORDS = ceil(P_DUT_IN_W/32).
REQ-003 Parameter P_DUT_OUT_W, default 256, DUT output vector width (32..8192); OUT_WORDS = ceil(P_DUT_OUT_W/32).
REQ-004 Parameter P_DFT_DEPTH, default 64, 32-bit words per scan chain buffer (1..256).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 axi_wr_en / axi_wr_addr / axi_wr_msg  in  1/32/32  word-addressed AXI-side write.
REQ-008 axi_rd_en / axi_rd_addr  in  1/32  word-addressed AXI-side read request.
REQ-009 axi_rd_msg / axi_rd_valid  out  32/1  read data and its valid strobe.
REQ-010 dut_input_vec  out  P_DUT_IN_W  DUT stimulus; dut_output_vec  in  P_DUT_OUT_W  DUT response.
REQ-011 dft_output_data  in  32*P_SC_NBR  per-chain scan word; dft_output_valid  in  P_SC_NBR  per-chain write strobe.
REQ-012 dft_clear  in  1  rewind all chain pointers; dft_full  out  P_SC_NBR  per-chain buffer full.
REQ-013 ctrl_state / ctrl_state_wen  in  32/1  controller state write; ctrl_opcode, ctrl_config  out  32  AXI-written control words.
REQ-014 in_load_start, out_cap_start  in  1  sequencer triggers; io_busy  out  1; in_load_done, out_cap_done  out  1  single-cycle pulses.

Function
REQ-015 Address map SHALL be: OPCODE 0x0 (RW), STATE 0x1 (RO), CONFIG 0x2 (RW), STATUS 0x3 (RO), DUT_IN 0x100+k (RW, k<IN_WORDS), DUT_OUT 0x200+k (RO, k<OUT_WORDS), DFT 0x1000+P_DFT_DEPTH*i+j (RO), TEST_IN 0xFF000000 (WO), TEST_OUT 0xFF000001 (RO).
REQ-016 Writes SHALL take effect on the edge where axi_wr_en=1; writes to RO or unmapped addresses SHALL be ignored.
REQ-017 Reads SHALL have 1-cycle latency: axi_rd_valid=1 and axi_rd_msg valid the cycle after axi_rd_en=1; unmapped reads SHALL return 0; exactly one source drives axi_rd_msg.
REQ-018 Same-cycle write and read of one address SHALL return the old value.
REQ-019 TEST_OUT SHALL return the last value written to TEST_IN (loopback).
REQ-020 STATE SHALL load ctrl_state when ctrl_state_wen=1; STATUS = {dft_full zero-extended to 16 bits in [31:16], 15'b0, io_busy}.
REQ-021 Sequencer FSM states IDLE, LOAD_IN, CAP_OUT; word counter width ceil(log2(max words))+1.
REQ-022 IDLE + in_load_start: enter LOAD_IN, counter=0; in_load_start has priority over a simultaneous out_cap_start, which is dropped.
REQ-023 LOAD_IN: each cycle copy DUT_IN word k into staging bits [32k+31:32k], k++; after word IN_WORDS-1, dut_input_vec SHALL update atomically from staging (excess bits truncated), in_load_done pulses, return to IDLE; total IN_WORDS+1 cycles start-to-done.
REQ-024 IDLE + out_cap_start: snapshot dut_output_vec that edge, enter CAP_OUT; one word/cycle written to DUT_OUT k; last word zero-padded above P_DUT_OUT_W; out_cap_done pulses the cycle after the final write; return to IDLE.
REQ-025 io_busy=1 in LOAD_IN/CAP_OUT; starts while busy SHALL be ignored.
REQ-026 AXI writes to DUT_IN during LOAD_IN are allowed; word k is taken as stored at the cycle k is copied.
REQ-027 Per chain i: dft_output_valid[i] with !dft_full[i] writes word at ptr[i], ptr[i]++; ptr[i] reaching P_DFT_DEPTH sets dft_full[i]; valid while full is dropped (no wrap).
REQ-028 dft_clear SHALL zero all pointers and dft_full, not contents; dft_clear wins over simultaneous valid.

Reset
REQ-029 reset SHALL zero every register, buffer, staging/snapshot, pointer and counter; FSM to IDLE; all outputs 0.
REQ-030 reset mid-LOAD_IN/CAP_OUT SHALL abort with no done pulse; dut_input_vec becomes 0.

Verification
REQ-031 Write 0xA5A5_0001 to TEST_IN, read TEST_OUT -> axi_rd_msg=0xA5A5_0001, axi_rd_valid one cycle after axi_rd_en.
REQ-032 Default params, DUT_IN words k=0..7 written k+1, pulse in_load_start -> dut_input_vec word k = k+1, in_load_done exactly 9 cycles after start, dut_input_vec unchanged before done.
REQ-033 dut_output_vec=0x…0F0E…0100 pattern, out_cap_start, change input next cycle -> DUT_OUT words reflect start-cycle snapshot; out_cap_done after 9 cycles.
REQ-034 P_DFT_DEPTH=4, chain 2 valid 6 times data 1..6 -> DFT words 1..4, dft_full[2]=1, STATUS[18]=1; dft_clear -> full=0, next word stored at j=0.
REQ-035 in_load_start and out_cap_start same cycle, then out_cap_start while busy -> only LOAD_IN runs, one in_load_done, no out_cap_done.
REQ-036 reset asserted 3 cycles into LOAD_IN -> io_busy=0, no in_load_done, dut_input_vec=0, all reads return 0.
